mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
// - Load/store initiator driving one read port and one write port of the word-wide data memory.
// - Takes single byte/half/word requests from the core pipeline.
// - Converts sub-word stores into aligned word read-modify-write and sign/zero-extends sub-word loads.
// - Returns one response per accepted request. Little-endian byte lanes.
// PARAMETERS
// - WIDTH  32  data/address width; only 32 supported (4 byte lanes)
// PORTS
// - clk           in   1      rising-edge clock
// - rst           in   1      asynchronous reset, active-low
// - req_valid     in   1      core request present
// - req_ready     out  1      LSU can accept (high only in IDLE)
// - req_we        in   1      1=store, 0=load
// - req_size      in   2      00 byte, 01 half, 10 word, 11 reserved
// - req_unsigned  in   1      loads: 1=zero-extend, 0=sign-extend
// - req_addr      in   WIDTH  byte address
// - req_wdata     in   WIDTH  store data, right-justified
// - resp_valid    out  1      response present
// - resp_ready    in   1      core takes response
// - resp_rdata    out  WIDTH  extended load data; 0 for stores
// - resp_err      out  1      misaligned/reserved-size request (see CONFIGURATION)
// - mem_ren       out  1      memory read enable
// - mem_raddr     out  WIDTH  word-aligned read address (low 2 bits 0)
// - mem_rdata     in   WIDTH  memory read data, valid one cycle after mem_ren
// - mem_wen       out  1      memory write enable
// - mem_waddr     out  WIDTH  word-aligned write address
// - mem_wdata     out  WIDTH  full merged write word
// BEHAVIOUR
// - Reset (rst low, async): state IDLE; all outputs 0, incl. req_ready.
//   - Any in-flight op is abandoned; no mem_wen issued afterwards.
// - FSM states: IDLE, RD, CAP, WR, RESP. Request fields latched at acceptance.
// - IDLE: req_ready=1.
//   - On req_valid: err -> RESP; word store -> WR; otherwise (load or sub-word store) -> RD.
// - RD: mem_ren=1 for one cycle at {addr[31:2],2'b00} -> CAP.
// - CAP: capture mem_rdata.
//   - Load: extract lane (byte at addr[1:0], half at addr[1]), extend, -> RESP.
//   - Store: merge req_wdata into the addressed lane(s), -> WR.
// - WR: mem_wen=1 for one cycle with merged word (word store: req_wdata as-is) -> RESP.
// - RESP: resp_valid=1; data/err held stable until resp_ready; then -> IDLE (no same-cycle re-accept).
// - Latency from accept edge to resp_valid:
//   - word load 3 cycles, sub-word store 4, word store 2, error 1.
// - mem_ren and mem_wen are never high in the same cycle.
// - Addresses not high during an access are driven 0.
// - Extension: byte sign bit = bit 7, half sign bit = bit 15.
// - Write address wrap: none needed; aligned address computed by masking, no arithmetic.
// CONFIGURATION
// - Macro MEM_LSU_ALIGN_CHECK_EN, defined:
//   - half with addr[0]=1, word with addr[1:0]!=0, or size 11 -> resp_err=1, resp_rdata=0.
//   - No mem_ren/mem_wen is issued for such a request.
// - Macro not defined:
//   - resp_err tied 0; size 11 treated as word.
//   - Misaligned low address bits ignored (half uses addr[1], word uses aligned word).
// TESTING (preload mem[0x100]=0x8899AABB)
// - LW 0x100 -> one mem_ren @0x100; resp_valid 3 cycles after accept; resp_rdata=0x8899AABB.
// - LB 0x103 signed -> 0xFFFFFF88; LBU 0x103 -> 0x00000088; LH 0x100 signed -> 0xFFFFAABB.
// - SH 0x102 wdata 0x00001234 -> mem_ren @0x100, then mem_wen @0x100 wdata 0x1234AABB; resp_rdata 0.
// - SW 0x104 0xDEADBEEF -> no mem_ren; single mem_wen @0x104 0xDEADBEEF; resp 2 cycles after accept.
// - LW 0x101 -> with macro: resp_err=1, no mem access; without: resp_rdata=0x8899AABB.
// - rst low during CAP of SB 0x100 -> outputs 0 immediately, mem[0x100] unchanged.
// - Also: resp_ready held low 5 cycles -> resp_valid/resp_rdata stable, req_ready 0 throughout.

Source files
------------

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - byte/half/word load-store unit over a word-wide memory
//
// Purpose:
//   Accepts single load/store requests from the core, turns sub-word stores
//   into an aligned read-modify-write, sign/zero-extends sub-word loads and
//   returns exactly one response per accepted request. Little-endian lanes.
//
// Optional feature macro: MEM_LSU_ALIGN_CHECK_EN
//   Defined   : misaligned half/word and reserved size 11 answer with
//               resp_err=1, resp_rdata=0 and never touch memory.
//   Undefined : resp_err is 0, size 11 acts as word, low address bits that
//               do not select a lane are ignored.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                 request fields, latched at acceptance
//   resp_valid/resp_ready     response handshake
//   resp_rdata, resp_err      extended load data (0 for stores), error flag
//   mem_ren/mem_raddr/mem_rdata   memory read port (data one cycle after ren)
//   mem_wen/mem_waddr/mem_wdata   memory write port (full merged word)

module mem_lsu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             mem_ren,
  output logic [WIDTH-1:0] mem_raddr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_wen,
  output logic [WIDTH-1:0] mem_waddr,
  output logic [WIDTH-1:0] mem_wdata
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic             we_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             err_q;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] wword_q;

  logic             accept;
  logic             req_err;
  logic [WIDTH-1:0] word_addr;
  logic [WIDTH-1:0] load_ext;
  logic [WIDTH-1:0] store_merge;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [WIDTH-1:0] lane_mask;

  assign accept = (state_q == IDLE) && req_valid;

`ifdef MEM_LSU_ALIGN_CHECK_EN
  assign req_err = (req_size == 2'b11)
                 || ((req_size == 2'b01) && req_addr[0])
                 || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign req_err = 1'b0;
`endif

  // Aligned address by masking only; no carry into upper bits.
  assign word_addr = {addr_q[WIDTH-1:2], 2'b00};

  // Lane extraction from the word read back in CAP.
  assign lane_b = 8'(mem_rdata >> {addr_q[1:0], 3'b000});
  assign lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_ext = mem_rdata;
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: load_ext = mem_rdata;
    endcase
  end

  // Store merge: replicate the store data across lanes and keep only the
  // addressed lane(s) from it; the rest comes from the word just read.
  always_comb begin
    lane_mask   = '1;
    store_merge = wdata_q;
    case (size_q)
      2'b00: begin
        lane_mask   = 32'h0000_00FF << {addr_q[1:0], 3'b000};
        store_merge = (mem_rdata & ~lane_mask) | ({4{wdata_q[7:0]}} & lane_mask);
      end
      2'b01: begin
        lane_mask   = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        store_merge = (mem_rdata & ~lane_mask) | ({2{wdata_q[15:0]}} & lane_mask);
      end
      default: begin
        lane_mask   = '1;
        store_merge = wdata_q;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                   state_d = RESP;
          else if (req_we && req_size[1]) state_d = WR;
          else                           state_d = RD;
        end
      end
      RD:   state_d = CAP;
      CAP:  state_d = we_q ? WR : RESP;
      WR:   state_d = RESP;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wword_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      err_q   <= req_err;
      rdata_q <= '0;
      wword_q <= req_wdata;
    end else if (state_q == CAP) begin
      if (we_q) wword_q <= store_merge;
      else      rdata_q <= load_ext;
    end
  end

  // Output decode; addresses and data are zero outside their access cycle.
  // req_ready is also qualified by rst so it reads 0 while reset is held.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_ren    = 1'b0;
    mem_raddr  = '0;
    mem_wen    = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: req_ready = rst;
      RD: begin
        mem_ren   = 1'b1;
        mem_raddr = word_addr;
      end
      WR: begin
        mem_wen   = 1'b1;
        mem_waddr = word_addr;
        mem_wdata = wword_q;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu

module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;

  int tests = 0;
  int fails = 0;

  int ren_cnt  = 0;
  int wen_cnt  = 0;
  int both_cnt = 0;
  logic [31:0] last_raddr = '0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic        preload;
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  mem_lsu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  // Word memory model: synchronous read, data one cycle after mem_ren.
  always @(posedge clk) begin
    if (preload) begin
      mem[64]   <= 32'h8899_AABB;
      mem[65]   <= 32'h0000_0000;
      mem_rdata <= 32'h0;
    end else begin
      if (mem_ren) mem_rdata <= mem[mem_raddr[9:2]];
      if (mem_wen) mem[mem_waddr[9:2]] <= mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (mem_ren) begin ren_cnt++; last_raddr = mem_raddr; end
    if (mem_wen) begin wen_cnt++; last_waddr = mem_waddr; last_wdata = mem_wdata; end
    if (mem_ren && mem_wen) both_cnt++;
  end

  // Issue one request starting #1 after a posedge; lat counts cycles from
  // the accept edge to the first cycle resp_valid is seen.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; preload = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    #1;
    tests++;
    if ({req_ready, resp_valid, resp_err, mem_ren, mem_wen, resp_rdata, mem_raddr, mem_waddr, mem_wdata} !== '0) begin
      fails++; $display("FAIL reset_outputs: req_ready=%b resp_valid=%b mem_ren=%b mem_wen=%b, required all 0", req_ready, resp_valid, mem_ren, mem_wen);
    end
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready: got %b required 1", req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_word_load();
    int lat; logic [31:0] rd; logic er; int r0; int w0;
    r0 = ren_cnt; w0 = wen_cnt;
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, rd, er);
    tests++;
    if (lat !== 3) begin fails++; $display("FAIL lw_latency: got %0d required 3", lat); end
    tests++;
    if (rd !== 32'h8899_AABB) begin fails++; $display("FAIL lw_data: got %h required 8899aabb", rd); end
    tests++;
    if (ren_cnt - r0 !== 1 || last_raddr !== 32'h100) begin
      fails++; $display("FAIL lw_mem_read: got %0d reads @%h required 1 @00000100", ren_cnt - r0, last_raddr);
    end
    tests++;
    if (wen_cnt - w0 !== 0) begin fails++; $display("FAIL lw_no_write: got %0d writes required 0", wen_cnt - w0); end
  endtask

  task automatic test_subword_load();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, lat, rd, er);
    tests++;
    if (rd !== 32'hFFFF_FF88) begin fails++; $display("FAIL lb_signed: got %h required ffffff88", rd); end
    do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, lat, rd, er);
    tests++;
    if (rd !== 32'h0000_0088) begin fails++; $display("FAIL lbu: got %h required 00000088", rd); end
    do_req(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, lat, rd, er);
    tests++;
    if (rd !== 32'hFFFF_AABB) begin fails++; $display("FAIL lh_signed: got %h required ffffaabb", rd); end
    do_req(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, lat, rd, er);
    tests++;
    if (rd !== 32'h0000_8899) begin fails++; $display("FAIL lhu_upper: got %h required 00008899", rd); end
    do_req(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, lat, rd, er);
    tests++;
    if (rd !== 32'hFFFF_FFAA) begin fails++; $display("FAIL lb_lane1: got %h required ffffffaa", rd); end
    tests++;
    if (lat !== 3) begin fails++; $display("FAIL lb_latency: got %0d required 3", lat); end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic er; int r0;
    r0 = ren_cnt;
    do_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, lat, rd, er);
`ifdef MEM_LSU_ALIGN_CHECK_EN
    tests++;
    if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL lw_misaligned_err: got err=%b data=%h required err=1 data=0", er, rd); end
    tests++;
    if (lat !== 1 || ren_cnt - r0 !== 0) begin fails++; $display("FAIL lw_misaligned_access: got lat=%0d reads=%0d required lat=1 reads=0", lat, ren_cnt - r0); end
`else
    tests++;
    if (er !== 1'b0 || rd !== 32'h8899_AABB) begin fails++; $display("FAIL lw_misaligned_ignored: got err=%b data=%h required err=0 data=8899aabb", er, rd); end
    tests++;
    if (lat !== 3 || last_raddr !== 32'h100) begin fails++; $display("FAIL lw_misaligned_addr: got lat=%0d raddr=%h required 3 @00000100", lat, last_raddr); end
`endif
  endtask

  task automatic test_half_store();
    int lat; logic [31:0] rd; logic er; int r0; int w0;
    r0 = ren_cnt; w0 = wen_cnt;
    do_req(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_1234, lat, rd, er);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL sh_latency: got %0d required 4", lat); end
    tests++;
    if (ren_cnt - r0 !== 1 || last_raddr !== 32'h100) begin fails++; $display("FAIL sh_read: got %0d @%h required 1 @00000100", ren_cnt - r0, last_raddr); end
    tests++;
    if (wen_cnt - w0 !== 1 || last_waddr !== 32'h100 || last_wdata !== 32'h1234_AABB) begin
      fails++; $display("FAIL sh_write: got %0d @%h data %h required 1 @00000100 data 1234aabb", wen_cnt - w0, last_waddr, last_wdata);
    end
    tests++;
    if (rd !== 32'h0 || er !== 1'b0) begin fails++; $display("FAIL sh_resp: got data=%h err=%b required 0/0", rd, er); end
  endtask

  task automatic test_word_store();
    int lat; logic [31:0] rd; logic er; int r0; int w0;
    r0 = ren_cnt; w0 = wen_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEAD_BEEF, lat, rd, er);
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL sw_latency: got %0d required 2", lat); end
    tests++;
    if (ren_cnt - r0 !== 0) begin fails++; $display("FAIL sw_no_read: got %0d reads required 0", ren_cnt - r0); end
    tests++;
    if (wen_cnt - w0 !== 1 || last_waddr !== 32'h104 || last_wdata !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL sw_write: got %0d @%h data %h required 1 @00000104 data deadbeef", wen_cnt - w0, last_waddr, last_wdata);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, lat, rd, er);
    tests++;
    if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL sw_readback: got %h required deadbeef", rd); end
  endtask

  task automatic test_backpressure();
    int n;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h1234_AABB || req_ready !== 1'b0) begin
        fails++; $display("FAIL backpressure_hold[%0d]: got valid=%b data=%h ready=%b required 1/1234aabb/0", i, resp_valid, resp_rdata, req_ready);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL backpressure_release: got valid=%b ready=%b required 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_midop();
    int w0;
    w0 = wen_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h0000_0055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    tests++;
    if ({req_ready, resp_valid, mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, resp_rdata} !== '0) begin
      fails++; $display("FAIL reset_midop_outputs: ready=%b valid=%b ren=%b wen=%b required all 0", req_ready, resp_valid, mem_ren, mem_wen);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (wen_cnt - w0 !== 0 || mem[64] !== 32'h1234_AABB) begin
      fails++; $display("FAIL reset_midop_mem: got %0d writes mem=%h required 0 writes mem=1234aabb", wen_cnt - w0, mem[64]);
    end
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_midop_ready: got %b required 1", req_ready); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_subword_load();
    test_misaligned();
    test_half_store();
    test_word_store();
    test_backpressure();
    test_reset_midop();
    tests++;
    if (both_cnt !== 0) begin fails++; $display("FAIL ren_wen_exclusive: got %0d overlaps required 0", both_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
